// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache/memory arbiter slice.
package cache_arb_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int LINE_WIDTH_DEF = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } arb_op_t;

    // One-hot owner encodings as seen on the grant output.
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_P0   = 2'b01;
    localparam logic [1:0] GRANT_P1   = 2'b10;

endpackage

// File: rtl/cache_arb_pick.sv
// Combinational winner selection for the two cache ports.
// CACHE_ARB_RR_EN selects round-robin; otherwise port 1 has fixed priority.
module cache_arb_pick
    import cache_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
`ifdef CACHE_ARB_RR_EN
    input  logic       last_grant,
`endif
    output logic [1:0] win
);

    // One-hot winner from the current requests
    always_comb begin
        win = GRANT_NONE;
`ifdef CACHE_ARB_RR_EN
        // last_grant holds the index of the previous owner; the other port wins a tie
        if (req0 && req1) begin
            win = last_grant ? GRANT_P0 : GRANT_P1;
        end else if (req1) begin
            win = GRANT_P1;
        end else if (req0) begin
            win = GRANT_P0;
        end
`else
        if (req1) begin
            win = GRANT_P1;
        end else if (req0) begin
            win = GRANT_P0;
        end
`endif
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between the I-cache (port 0) and D-cache
// (port 1). One transaction at a time; completion is steered to its owner.
// Optional build macro: CACHE_ARB_RR_EN (round-robin pick instead of fixed priority).
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  p0_r,
    input  logic                  p0_w,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [LINE_WIDTH-1:0] p0_w_data,
    output logic [LINE_WIDTH-1:0] p0_r_data,
    output logic                  p0_ready,
    input  logic                  p1_r,
    input  logic                  p1_w,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [LINE_WIDTH-1:0] p1_w_data,
    output logic [LINE_WIDTH-1:0] p1_r_data,
    output logic                  p1_ready,
    output logic                  mem_r,
    output logic                  mem_w,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_w_data,
    input  logic [LINE_WIDTH-1:0] mem_r_data,
    input  logic                  mem_ready,
    output logic [1:0]            grant
);

    arb_state_t            state;
    logic                  req0;
    logic                  req1;
    logic [1:0]            win;
    arb_op_t               sel_op;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LINE_WIDTH-1:0] sel_data;
`ifdef CACHE_ARB_RR_EN
    logic                  last_grant;
`endif

    assign req0 = p0_r | p0_w;
    assign req1 = p1_r | p1_w;

    cache_arb_pick u_pick (
        .req0       (req0),
        .req1       (req1),
`ifdef CACHE_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .win        (win)
    );

    // Mux the winning port's op, address and line; a write beats a read
    always_comb begin
        if (win == GRANT_P1) begin
            sel_op   = p1_w ? OP_WR : OP_RD;
            sel_addr = p1_addr;
            sel_data = p1_w_data;
        end else begin
            sel_op   = p0_w ? OP_WR : OP_RD;
            sel_addr = p0_addr;
            sel_data = p0_w_data;
        end
    end

    // Transaction FSM; the registered memory outputs double as the transaction buffer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            mem_r      <= 1'b0;
            mem_w      <= 1'b0;
            mem_addr   <= '0;
            mem_w_data <= '0;
            grant      <= GRANT_NONE;
`ifdef CACHE_ARB_RR_EN
            last_grant <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win != GRANT_NONE) begin
                        state      <= (win == GRANT_P1) ? BUSY1 : BUSY0;
                        mem_r      <= (sel_op == OP_RD);
                        mem_w      <= (sel_op == OP_WR);
                        mem_addr   <= sel_addr;
                        mem_w_data <= sel_data;
                        grant      <= win;
`ifdef CACHE_ARB_RR_EN
                        last_grant <= (win == GRANT_P1);
`endif
                    end
                end
                BUSY0, BUSY1: begin
                    if (mem_ready) begin
                        state <= IDLE;
                        mem_r <= 1'b0;
                        mem_w <= 1'b0;
                        grant <= GRANT_NONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    mem_r <= 1'b0;
                    mem_w <= 1'b0;
                    grant <= GRANT_NONE;
                end
            endcase
        end
    end

    // Completion is steered by state so a stray mem_ready in IDLE is dropped
    always_comb begin
        p0_ready = (state == BUSY0) && mem_ready;
        p1_ready = (state == BUSY1) && mem_ready;
    end

    assign p0_r_data = mem_r_data;
    assign p1_r_data = mem_r_data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a per-cycle vector table plus
// hand-written sequences for reset-mid-transaction and continuous contention.
module tb_cache_mem_arbiter;

    localparam logic [127:0] D_DB = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    localparam logic [127:0] D1   = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
    localparam logic [127:0] D2   = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
    localparam logic [127:0] D3   = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
    localparam logic [127:0] D4   = 128'h4444_5555_6666_7777_8888_9999_AAAA_BBBB;

    logic         clk;
    logic         rstn;
    logic         p0_r, p0_w, p1_r, p1_w;
    logic [31:0]  p0_addr, p1_addr, mem_addr;
    logic [127:0] p0_w_data, p1_w_data, p0_r_data, p1_r_data;
    logic [127:0] mem_w_data, mem_r_data;
    logic         p0_ready, p1_ready, mem_r, mem_w, mem_ready;
    logic [1:0]   grant;

    int n_vec  = 0;
    int n_miss = 0;

    cache_mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .p0_r       (p0_r),
        .p0_w       (p0_w),
        .p0_addr    (p0_addr),
        .p0_w_data  (p0_w_data),
        .p0_r_data  (p0_r_data),
        .p0_ready   (p0_ready),
        .p1_r       (p1_r),
        .p1_w       (p1_w),
        .p1_addr    (p1_addr),
        .p1_w_data  (p1_w_data),
        .p1_r_data  (p1_r_data),
        .p1_ready   (p1_ready),
        .mem_r      (mem_r),
        .mem_w      (mem_w),
        .mem_addr   (mem_addr),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data),
        .mem_ready  (mem_ready),
        .grant      (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         p0r, p0w;
        logic [31:0]  p0a;
        logic [127:0] p0d;
        logic         p1r, p1w;
        logic [31:0]  p1a;
        logic [127:0] p1d;
        logic         mrdy;
        logic [127:0] mrd;
        logic         er, ew;
        logic [31:0]  ea;
        logic [127:0] ed;
        logic [1:0]   eg;
        logic         e0, e1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic p0r, input logic p0w, input logic [31:0] p0a, input logic [127:0] p0d,
        input logic p1r, input logic p1w, input logic [31:0] p1a, input logic [127:0] p1d,
        input logic mrdy, input logic [127:0] mrd,
        input logic er, input logic ew, input logic [31:0] ea, input logic [127:0] ed,
        input logic [1:0] eg, input logic e0, input logic e1);
        vec_t v;
        v.p0r = p0r; v.p0w = p0w; v.p0a = p0a; v.p0d = p0d;
        v.p1r = p1r; v.p1w = p1w; v.p1a = p1a; v.p1d = p1d;
        v.mrdy = mrdy; v.mrd = mrd;
        v.er = er; v.ew = ew; v.ea = ea; v.ed = ed; v.eg = eg; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        p0_r = 0; p0_w = 0; p0_addr = '0; p0_w_data = '0;
        p1_r = 0; p1_w = 0; p1_addr = '0; p1_w_data = '0;
        mem_ready = 0; mem_r_data = '0;
    endtask

    logic [1:0] exp_g [4];

    initial begin
        rstn = 1'b0;
        drive_idle();

        // Reset values
        #3;
        chk("rst_mem_r", {127'd0, mem_r}, 128'd0);
        chk("rst_mem_w", {127'd0, mem_w}, 128'd0);
        chk("rst_mem_addr", {96'd0, mem_addr}, 128'd0);
        chk("rst_mem_w_data", mem_w_data, 128'd0);
        chk("rst_grant", {126'd0, grant}, 128'd0);
        chk("rst_p0_ready", {127'd0, p0_ready}, 128'd0);
        chk("rst_p1_ready", {127'd0, p1_ready}, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // p0r p0w p0a p0d  p1r p1w p1a p1d  mrdy mrd  er ew ea ed  eg e0 e1
        // single read, port 0
        vecs.push_back(mk(1,0,32'h40,'0, 0,0,0,'0, 0,'0,   0,0,0,'0,      2'b00,0,0));
        vecs.push_back(mk(1,0,32'h40,'0, 0,0,0,'0, 0,'0,   1,0,32'h40,'0, 2'b01,0,0));
        vecs.push_back(mk(1,0,32'h40,'0, 0,0,0,'0, 0,'0,   1,0,32'h40,'0, 2'b01,0,0));
        vecs.push_back(mk(1,0,32'h40,'0, 0,0,0,'0, 0,'0,   1,0,32'h40,'0, 2'b01,0,0));
        vecs.push_back(mk(1,0,32'h40,'0, 0,0,0,'0, 0,'0,   1,0,32'h40,'0, 2'b01,0,0));
        vecs.push_back(mk(1,0,32'h40,'0, 0,0,0,'0, 1,D_DB, 1,0,32'h40,'0, 2'b01,1,0));
        vecs.push_back(mk(0,0,0,'0,      0,0,0,'0, 0,'0,   0,0,0,'0,      2'b00,0,0));
        // simultaneous: port 1 write first, one IDLE gap, then port 0 read
        vecs.push_back(mk(1,0,32'h100,'0, 0,1,32'h200,D1, 0,'0, 0,0,0,'0,        2'b00,0,0));
        vecs.push_back(mk(1,0,32'h100,'0, 0,1,32'h200,D1, 0,'0, 0,1,32'h200,D1,  2'b10,0,0));
        vecs.push_back(mk(1,0,32'h100,'0, 0,1,32'h200,D1, 1,D4, 0,1,32'h200,D1,  2'b10,0,1));
        vecs.push_back(mk(1,0,32'h100,'0, 0,0,0,'0,       0,'0, 0,0,0,'0,        2'b00,0,0));
        vecs.push_back(mk(1,0,32'h100,'0, 0,0,0,'0,       0,'0, 1,0,32'h100,'0,  2'b01,0,0));
        vecs.push_back(mk(1,0,32'h100,'0, 0,0,0,'0,       1,D2, 1,0,32'h100,'0,  2'b01,1,0));
        vecs.push_back(mk(0,0,0,'0,       0,0,0,'0,       0,'0, 0,0,0,'0,        2'b00,0,0));
        // write-back then refill on port 1 while port 0 waits
        vecs.push_back(mk(1,0,32'h500,'0, 0,1,32'h300,D2, 0,'0,   0,0,0,'0,       2'b00,0,0));
        vecs.push_back(mk(1,0,32'h500,'0, 0,1,32'h300,D2, 0,'0,   0,1,32'h300,D2, 2'b10,0,0));
        vecs.push_back(mk(1,0,32'h500,'0, 0,1,32'h300,D2, 1,'0,   0,1,32'h300,D2, 2'b10,0,1));
        vecs.push_back(mk(1,0,32'h500,'0, 1,0,32'h400,'0, 0,'0,   0,0,0,'0,       2'b00,0,0));
        vecs.push_back(mk(1,0,32'h500,'0, 1,0,32'h400,'0, 0,'0,   1,0,32'h400,'0, 2'b10,0,0));
        vecs.push_back(mk(1,0,32'h500,'0, 1,0,32'h400,'0, 1,D4,   1,0,32'h400,'0, 2'b10,0,1));
        vecs.push_back(mk(1,0,32'h500,'0, 0,0,0,'0,       0,'0,   0,0,0,'0,       2'b00,0,0));
        vecs.push_back(mk(1,0,32'h500,'0, 0,0,0,'0,       0,'0,   1,0,32'h500,'0, 2'b01,0,0));
        vecs.push_back(mk(1,0,32'h500,'0, 0,0,0,'0,       1,D_DB, 1,0,32'h500,'0, 2'b01,1,0));
        vecs.push_back(mk(0,0,0,'0,       0,0,0,'0,       0,'0,   0,0,0,'0,       2'b00,0,0));
        // stray mem_ready in IDLE
        vecs.push_back(mk(0,0,0,'0,       0,0,0,'0,       1,D3,   0,0,0,'0,       2'b00,0,0));
        // port 0 drops its request one cycle after grant
        vecs.push_back(mk(1,0,32'h600,'0, 0,0,0,'0, 0,'0,   0,0,0,'0,       2'b00,0,0));
        vecs.push_back(mk(1,0,32'h600,'0, 0,0,0,'0, 0,'0,   1,0,32'h600,'0, 2'b01,0,0));
        vecs.push_back(mk(0,0,0,'0,       0,0,0,'0, 0,'0,   1,0,32'h600,'0, 2'b01,0,0));
        vecs.push_back(mk(0,0,0,'0,       0,0,0,'0, 0,'0,   1,0,32'h600,'0, 2'b01,0,0));
        vecs.push_back(mk(0,0,0,'0,       0,0,0,'0, 1,D1,   1,0,32'h600,'0, 2'b01,1,0));
        vecs.push_back(mk(0,0,0,'0,       0,0,0,'0, 0,'0,   0,0,0,'0,       2'b00,0,0));
        // read and write both raised: write wins
        vecs.push_back(mk(1,1,32'h700,D3, 0,0,0,'0, 0,'0, 0,0,0,'0,       2'b00,0,0));
        vecs.push_back(mk(1,1,32'h700,D3, 0,0,0,'0, 0,'0, 0,1,32'h700,D3, 2'b01,0,0));
        vecs.push_back(mk(1,1,32'h700,D3, 0,0,0,'0, 1,'0, 0,1,32'h700,D3, 2'b01,1,0));
        vecs.push_back(mk(0,0,0,'0,       0,0,0,'0, 0,'0, 0,0,0,'0,       2'b00,0,0));

        foreach (vecs[i]) begin
            p0_r = vecs[i].p0r; p0_w = vecs[i].p0w; p0_addr = vecs[i].p0a; p0_w_data = vecs[i].p0d;
            p1_r = vecs[i].p1r; p1_w = vecs[i].p1w; p1_addr = vecs[i].p1a; p1_w_data = vecs[i].p1d;
            mem_ready = vecs[i].mrdy; mem_r_data = vecs[i].mrd;
            #1;
            chk($sformatf("v%0d_mem_r", i), {127'd0, mem_r}, {127'd0, vecs[i].er});
            chk($sformatf("v%0d_mem_w", i), {127'd0, mem_w}, {127'd0, vecs[i].ew});
            chk($sformatf("v%0d_grant", i), {126'd0, grant}, {126'd0, vecs[i].eg});
            chk($sformatf("v%0d_p0_ready", i), {127'd0, p0_ready}, {127'd0, vecs[i].e0});
            chk($sformatf("v%0d_p1_ready", i), {127'd0, p1_ready}, {127'd0, vecs[i].e1});
            if (vecs[i].er || vecs[i].ew)
                chk($sformatf("v%0d_mem_addr", i), {96'd0, mem_addr}, {96'd0, vecs[i].ea});
            if (vecs[i].ew)
                chk($sformatf("v%0d_mem_w_data", i), mem_w_data, vecs[i].ed);
            if (vecs[i].e0)
                chk($sformatf("v%0d_p0_r_data", i), p0_r_data, vecs[i].mrd);
            if (vecs[i].e1)
                chk($sformatf("v%0d_p1_r_data", i), p1_r_data, vecs[i].mrd);
            @(negedge clk);
        end
        drive_idle();

        // Reset two cycles into a port 1 write
        p1_w = 1; p1_addr = 32'h800; p1_w_data = D1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("busy1_mem_w", {127'd0, mem_w}, 128'd1);
        p1_w = 0;
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_mem_w", {127'd0, mem_w}, 128'd0);
        chk("async_rst_grant", {126'd0, grant}, 128'd0);
        chk("async_rst_mem_r", {127'd0, mem_r}, 128'd0);
        @(negedge clk);
        rstn = 1'b1;
        mem_ready = 1; mem_r_data = D2;
        #1;
        chk("post_rst_p1_ready", {127'd0, p1_ready}, 128'd0);
        chk("post_rst_p0_ready", {127'd0, p0_ready}, 128'd0);
        @(negedge clk);
        mem_ready = 0;
        p0_r = 1; p0_addr = 32'h900;
        #1;
        chk("post_rst_idle_grant", {126'd0, grant}, 128'd0);
        @(negedge clk);
        #1;
        chk("post_rst_mem_r", {127'd0, mem_r}, 128'd1);
        chk("post_rst_grant", {126'd0, grant}, {126'd0, 2'b01});
        chk("post_rst_mem_addr", {96'd0, mem_addr}, 128'h900);
        mem_ready = 1; mem_r_data = D3;
        #1;
        chk("post_rst_p0_ready", {127'd0, p0_ready}, 128'd1);
        chk("post_rst_p0_r_data", p0_r_data, D3);
        @(negedge clk);
        p0_r = 0; mem_ready = 0;
        #1;
        chk("post_rst_done_grant", {126'd0, grant}, 128'd0);
        @(negedge clk);

        // Both ports requesting continuously for four transactions
`ifdef CACHE_ARB_RR_EN
        exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
`else
        exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b10; exp_g[3] = 2'b10;
`endif
        p0_r = 1; p0_addr = 32'hA00;
        p1_r = 1; p1_addr = 32'hB00;
        #1;
        chk("cont_idle_grant", {126'd0, grant}, 128'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("cont%0d_grant", k), {126'd0, grant}, {126'd0, exp_g[k]});
            chk($sformatf("cont%0d_mem_addr", k), {96'd0, mem_addr},
                (exp_g[k] == 2'b10) ? 128'hB00 : 128'hA00);
            mem_ready = 1;
            #1;
            chk($sformatf("cont%0d_p1_ready", k), {127'd0, p1_ready}, {127'd0, exp_g[k][1]});
            chk($sformatf("cont%0d_p0_ready", k), {127'd0, p0_ready}, {127'd0, exp_g[k][0]});
            @(negedge clk);
            mem_ready = 0;
            #1;
            chk($sformatf("cont%0d_gap_grant", k), {126'd0, grant}, 128'd0);
        end
        drive_idle();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
